// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one registered ALU between NUM_REQ requesters.
// Accepted operations run through IDLE -> EXEC -> RESP and return a single tagged response.
module alu_rr_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_err,
    output logic                     busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [3:0]           op_q, op_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]   above_last;
    logic [NUM_REQ-1:0]   hi_valid;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [ID_W-1:0]      hi_idx, lo_idx, grant_idx;
    logic                 grant_found;
    logic                 accept;

    logic [WIDTH-1:0]     a_sel, b_sel;
    logic [3:0]           op_sel;
    logic [2*WIDTH-1:0]   a_ext, b_ext, alu_result;
    logic                 alu_err;

    // Requesters above the last winner get first pick; otherwise wrap to the lowest valid index.
    always_comb begin
        above_last   = '0;
        hi_idx       = '0;
        lo_idx       = '0;
        grant_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            above_last[i] = (ID_W'(i) > last_q);
        end
        hi_valid = req_valid & above_last;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (hi_valid[i]) hi_idx = ID_W'(i);
            if (req_valid[i]) lo_idx = ID_W'(i);
        end
        grant_found = |req_valid;
        grant_idx   = (|hi_valid) ? hi_idx : lo_idx;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant_onehot[i] = grant_found && (ID_W'(i) == grant_idx);
        end
    end

    assign req_ready = (state_q == StIdle && !rst) ? grant_onehot : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_W'(i) == grant_idx) begin
                a_sel  = req_a[i*WIDTH +: WIDTH];
                b_sel  = req_b[i*WIDTH +: WIDTH];
                op_sel = req_op[i*4 +: 4];
            end
        end
    end

    // Arithmetic runs at 2*WIDTH so carry and borrow land in the upper half.
    always_comb begin
        a_ext      = {{WIDTH{1'b0}}, a_q};
        b_ext      = {{WIDTH{1'b0}}, b_q};
        alu_err    = op_q[3];
        alu_result = '0;
        case (op_q)
            4'd0:    alu_result = a_ext + b_ext;
            4'd1:    alu_result = a_ext - b_ext;
            4'd2:    alu_result = {{WIDTH{1'b0}}, a_q & b_q};
            4'd3:    alu_result = {{WIDTH{1'b0}}, a_q | b_q};
            4'd4:    alu_result = {{WIDTH{1'b0}}, ~(a_q & b_q)};
            4'd5:    alu_result = {{WIDTH{1'b0}}, ~(a_q | b_q)};
            4'd6:    alu_result = {{WIDTH{1'b0}}, a_q ^ b_q};
            4'd7:    alu_result = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    op_d    = op_sel;
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_result_d = alu_result;
                rsp_err_d    = alu_err;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_q       <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one ALU datapath (ADD/SUB/AND/OR/NAND/NOR/XOR/XNOR, WIDTH-bit operands, 2*WIDTH-bit result) between NUM_REQ requesters.
- Arbitration is round-robin. Requests use a valid/ready handshake. Operands are registered, and results are returned through a single registered response channel tagged with the requester ID.
- Sits between the ALU and client blocks so one ALU instance serves multiple sequencers.

Parameters:
- WIDTH, 16, operand width in bits; result width is 2*WIDTH.
- NUM_REQ, 4, number of requesters, 2..8.
- ID_W, 2, requester-ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i = requester i has an operation pending.
- req_a  input  NUM_REQ*WIDTH  operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand b; same packing as req_a.
- req_op  input  NUM_REQ*4  op_select per requester, slice [i*4 +: 4].
- req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_result  output  2*WIDTH  ALU result.
- rsp_err  output  1  op code was illegal (8..15).
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States are IDLE, EXEC and RESP.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE and the round-robin pointer last goes to NUM_REQ-1, so requester 0 wins first.
  - rsp_valid, rsp_id, rsp_result, rsp_err and busy all go to 0.
  - req_ready is 0 throughout the reset cycle.
  - Reset in any state discards the in-flight operation; no response is produced.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first requester with req_valid=1, searching (last+1), (last+2), ... modulo NUM_REQ.
  - req_ready is all zero if no requester is valid, and always zero outside IDLE.
  - On a transfer: latch a, b, op and the grant index into internal registers, set last to the grant index, and go to EXEC.
- EXEC (exactly 1 cycle):
  - Apply the latched operands to the ALU.
  - Register the result into rsp_result, the grant index into rsp_id and the illegal-op flag into rsp_err.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_result and rsp_err stable until rsp_ready=1.
  - On the handshake edge, clear rsp_valid and go to IDLE.
  - No new request is accepted while in RESP.
- Latency and throughput:
  - An accept at edge N gives rsp_valid=1 after edge N+1.
  - The minimum spacing between accepts is 3 cycles when rsp_ready is tied high.
- Op encoding (upper bit 0): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
- Result width rules (operands are zero-extended):
  - ADD is computed in 2*WIDTH bits, so the carry appears in bit WIDTH.
  - SUB is computed as 2*WIDTH-bit two's complement, so 3-5 gives all ones down to ...FFFE.
  - Logical ops operate on WIDTH bits; the upper WIDTH bits are 0, including for NAND, NOR and XNOR.
- Ops 8..15 give rsp_result=0 and rsp_err=1. They are still granted and still produce a response.
- Fairness:
  - A requester that has just been served has lowest priority in the next arbitration.
  - Any continuously valid requester is served within NUM_REQ grants.
- Requesters must hold a, b and op stable while req_valid=1 and not yet accepted. The block samples them only on the transfer edge.
- If req_valid[i] drops before it is granted, nothing is recorded for requester i.

Test Plan:
- Single requester: req 0, a=0x0005, b=0x0003, op=0, rsp_ready=1 -> req_ready[0] high in the accept cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=0x00000008, rsp_err=0.
- All 8 ops on req 2 with the sequence ADD 0xFFFF+0x0001, SUB 3-5, AND 0xFFFF&0x0001, OR 0xF0F0|0, NAND 0xFFFF,0x00FF, NOR 0,0x00FF, XOR 0xAAAA^0x5555, XNOR 0xAAAA,0x5555 -> results 0x00010000, 0xFFFFFFFE, 0x00000001, 0x0000F0F0, 0x0000FF00, 0x0000FF00, 0x0000FFFF, 0x00000000.
- Round robin: all 4 req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0,1, and rsp_id follows the same order; next drop req 1 -> order continues 2,3,0,2.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_result stay stable, busy=1, req_ready=0 for all requesters; rsp_ready=1 -> IDLE next cycle and the next accept is possible in that cycle.
- Illegal op: op=0xA from req 3 -> rsp_err=1, rsp_result=0, rsp_id=3; the next legal op returns rsp_err=0.
- Reset mid-op: assert rst during EXEC, then during RESP -> the next cycle has rsp_valid=0, busy=0, state IDLE; the next grant goes to req 0 when all requesters are valid.
